fifo_wr_stream_adapter: RTL and testbench

//  Write-domain front end of the async FIFO; sits directly upstream of the write-pointer/full stage.

---
 rtl/fifo_wr_stream_adapter_if.sv | 29 ++
 rtl/fifo_wr_stream_adapter.sv | 114 +++++++++++
 tb/tb_fifo_wr_stream_adapter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fifo_wr_stream_adapter_if.sv
// Write-side bundle between the producer/FIFO environment and fifo_wr_stream_adapter.
// master: producer and write-pointer stage; slave: the adapter itself.
interface fifo_wr_stream_adapter_if #(
  parameter int NUM_BITS = 4,
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 16
);
  logic                s_valid;
  logic [DATA_W-1:0]   s_data;
  logic                s_ready;
  logic                w_en;
  logic [DATA_W-1:0]   w_data;
  logic                full;
  logic [NUM_BITS-1:0] w_ptr_bin;
  logic [NUM_BITS-1:0] rd_ptr_gray_sync;
  logic [NUM_BITS-1:0] wr_level;
  logic                almost_full;
  logic [CNT_W-1:0]    wr_count;

  modport master (
    output s_valid, s_data, full, w_ptr_bin, rd_ptr_gray_sync,
    input  s_ready, w_en, w_data, wr_level, almost_full, wr_count
  );

  modport slave (
    input  s_valid, s_data, full, w_ptr_bin, rd_ptr_gray_sync,
    output s_ready, w_en, w_data, wr_level, almost_full, wr_count
  );
endinterface

// File: rtl/fifo_wr_stream_adapter.sv
// Write-domain front end of the async FIFO: 2-entry skid buffer feeding the FIFO write port,
// plus registered occupancy / almost_full derived from the local and synchronised pointers.
module fifo_wr_stream_adapter #(
  parameter int NUM_BITS  = 4,
  parameter int DATA_W    = 8,
  parameter int AF_THRESH = 6,
  parameter int CNT_W     = 16
) (
  input  logic                      w_clk,
  input  logic                      w_rst,
  fifo_wr_stream_adapter_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state_r;
  logic [DATA_W-1:0]   head_r;
  logic [DATA_W-1:0]   skid_r;
  logic [NUM_BITS-1:0] wr_level_r;
  logic                almost_full_r;
  logic [CNT_W-1:0]    wr_count_r;

  logic                push_s;
  logic                pop_s;
  logic [NUM_BITS-1:0] rd_bin_s;
  logic [NUM_BITS-1:0] wr_level_next_s;

  function automatic logic [NUM_BITS-1:0] gray2bin(input logic [NUM_BITS-1:0] g);
    logic [NUM_BITS-1:0] b;
    b[NUM_BITS-1] = g[NUM_BITS-1];
    for (int i = NUM_BITS - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // s_ready depends on the state register only; reset gates both strobes
  assign bus.s_ready = (state_r != TWO) & ~w_rst;
  assign pop_s       = (state_r != EMPTY) & ~bus.full & ~w_rst;
  assign push_s      = bus.s_valid & bus.s_ready;

  assign bus.w_en        = pop_s;
  assign bus.w_data      = head_r;
  assign bus.wr_level    = wr_level_r;
  assign bus.almost_full = almost_full_r;
  assign bus.wr_count    = wr_count_r;

  // Unsigned modular subtraction stays correct across pointer wrap
  assign rd_bin_s        = gray2bin(bus.rd_ptr_gray_sync);
  assign wr_level_next_s = bus.w_ptr_bin - rd_bin_s;

  // Skid-buffer FSM, data registers, level flags and write counter
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_r       <= EMPTY;
      wr_level_r    <= {NUM_BITS{1'b0}};
      almost_full_r <= 1'b0;
      wr_count_r    <= {CNT_W{1'b0}};
    end else begin
      wr_level_r    <= wr_level_next_s;
      almost_full_r <= (wr_level_next_s >= NUM_BITS'(AF_THRESH));
      if (pop_s) begin
        wr_count_r <= wr_count_r + CNT_W'(1);
      end else begin
        wr_count_r <= wr_count_r;
      end

      case (state_r)
        EMPTY: begin
          if (push_s) begin
            head_r  <= bus.s_data;
            state_r <= ONE;
          end else begin
            state_r <= EMPTY;
          end
        end
        ONE: begin
          case ({push_s, pop_s})
            2'b10: begin
              skid_r  <= bus.s_data;
              state_r <= TWO;
            end
            2'b01: begin
              state_r <= EMPTY;
            end
            2'b11: begin
              head_r  <= bus.s_data;
              state_r <= ONE;
            end
            default: begin
              state_r <= ONE;
            end
          endcase
        end
        TWO: begin
          if (pop_s) begin
            head_r  <= skid_r;
            state_r <= ONE;
          end else begin
            state_r <= TWO;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_stream_adapter.sv
// Bench for fifo_wr_stream_adapter: directed scenarios followed by random traffic,
// all checked against a queue-based model of the buffer and an arithmetic level model.
module tb_fifo_wr_stream_adapter;
  localparam int NUM_BITS  = 4;
  localparam int DATA_W    = 8;
  localparam int AF_THRESH = 6;
  localparam int CNT_W     = 16;

  logic w_clk = 1'b0;
  logic w_rst;

  fifo_wr_stream_adapter_if #(.NUM_BITS(NUM_BITS), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  fifo_wr_stream_adapter #(
    .NUM_BITS (NUM_BITS),
    .DATA_W   (DATA_W),
    .AF_THRESH(AF_THRESH),
    .CNT_W    (CNT_W)
  ) dut (
    .w_clk(w_clk),
    .w_rst(w_rst),
    .bus  (bus)
  );

  always #5 w_clk = ~w_clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] q[$];
  logic [NUM_BITS-1:0] m_level = '0;
  logic                m_af = 1'b0;
  logic [CNT_W-1:0]    m_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Occupancy from pointer values: find the binary value whose Gray code matches, then subtract
  function automatic logic [NUM_BITS-1:0] ref_level(input logic [NUM_BITS-1:0] wp,
                                                    input logic [NUM_BITS-1:0] g);
    int r = 0;
    for (int k = 0; k < (1 << NUM_BITS); k++) begin
      if (((k ^ (k >> 1)) & ((1 << NUM_BITS) - 1)) == int'(g)) r = k;
    end
    return NUM_BITS'((int'(wp) - r + (1 << NUM_BITS)) % (1 << NUM_BITS));
  endfunction

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model
  task automatic cycle(input logic rst, input logic v, input logic [DATA_W-1:0] d,
                       input logic f, input logic [NUM_BITS-1:0] wp,
                       input logic [NUM_BITS-1:0] rg);
    logic exp_ready;
    logic exp_wen;
    w_rst                = rst;
    bus.s_valid          = v;
    bus.s_data           = d;
    bus.full             = f;
    bus.w_ptr_bin        = wp;
    bus.rd_ptr_gray_sync = rg;
    @(negedge w_clk);
    exp_ready = !rst && (q.size() < 2);
    exp_wen   = !rst && (q.size() > 0) && !f;
    chk("s_ready", 32'(bus.s_ready), 32'(exp_ready));
    chk("w_en", 32'(bus.w_en), 32'(exp_wen));
    if (!rst && q.size() > 0) chk("w_data", 32'(bus.w_data), 32'(q[0]));
    chk("wr_level", 32'(bus.wr_level), 32'(m_level));
    chk("almost_full", 32'(bus.almost_full), 32'(m_af));
    chk("wr_count", 32'(bus.wr_count), 32'(m_cnt));
    if (rst) begin
      q.delete();
      m_level = '0;
      m_af    = 1'b0;
      m_cnt   = '0;
    end else begin
      if (exp_wen) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 1'b1;
      end
      if (v && exp_ready) q.push_back(d);
      m_level = ref_level(wp, rg);
      m_af    = (int'(m_level) >= AF_THRESH);
    end
    @(posedge w_clk);
    #1;
  endtask

  initial begin
    w_rst                = 1'b1;
    bus.s_valid          = 1'b1;
    bus.s_data           = 8'h00;
    bus.full             = 1'b0;
    bus.w_ptr_bin        = 4'd0;
    bus.rd_ptr_gray_sync = 4'd0;
    @(posedge w_clk);
    #1;

    // Reset held two cycles with valid high, then release
    cycle(1'b1, 1'b1, 8'hEE, 1'b0, 4'd0, 4'd0);
    cycle(1'b1, 1'b1, 8'hEE, 1'b0, 4'd0, 4'd0);
    chk("rst_count", 32'(bus.wr_count), 32'd0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0);

    // Streaming 0x01..0x10 with full low
    for (int i = 1; i <= 16; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0);
    chk("stream_count", 32'(bus.wr_count), 32'd16);

    // Backpressure: full high while offering 0xA0..0xA2, then release
    cycle(1'b0, 1'b1, 8'hA0, 1'b1, 4'd0, 4'd0);
    cycle(1'b0, 1'b1, 8'hA1, 1'b1, 4'd0, 4'd0);
    cycle(1'b0, 1'b1, 8'hA2, 1'b1, 4'd0, 4'd0);
    chk("bp_ready_low", 32'(bus.s_ready), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'hA2, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0);

    // Simultaneous push/pop while holding one word
    cycle(1'b0, 1'b1, 8'h33, 1'b1, 4'd0, 4'd0);
    cycle(1'b0, 1'b1, 8'h44, 1'b0, 4'd0, 4'd0);
    chk("pushpop_data", 32'(bus.w_data), 32'h44);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0);

    // Level across pointer wrap: w=1, r=13 -> 4; w=3 -> 6 with almost_full
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 4'b1011);
    chk("level_wrap", 32'(bus.wr_level), 32'd4);
    chk("af_below", 32'(bus.almost_full), 32'd0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 4'd3, 4'b1011);
    chk("level_six", 32'(bus.wr_level), 32'd6);
    chk("af_at_thresh", 32'(bus.almost_full), 32'd1);

    // Mid-operation reset with both entries held and full high
    cycle(1'b0, 1'b1, 8'h55, 1'b1, 4'd0, 4'd0);
    cycle(1'b0, 1'b1, 8'h66, 1'b1, 4'd0, 4'd0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0);
    chk("midrst_count", 32'(bus.wr_count), 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
            ($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
